cmd_line_responder: RTL and testbench
=====================================

Name: cmd_line_responder

Overview:
- Synthesizable command target for host-issued text commands, e.g. strings pushed from a DPI-C/Tcl command channel.
- Accepts an ASCII command line over a byte valid/ready stream, parses it, and updates or reads three registers: `a`, `b`, `sel`.
- The registers drive a 2:1 mux output. It is the same mux function the team's scale_mux benches exercise.
- Returns an ASCII response line over a second byte stream, so tests can be driven and checked entirely through text commands.

Parameters:
- WIDTH, 8, width of `a`, `b`, `mux_out`. Must be a multiple of 4; HEXD = WIDTH/4 hex digits.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  host has a command byte.
- rx_data  input  8  ASCII command byte.
- rx_ready  output  1  block accepts rx_data this cycle; a byte transfers when rx_valid && rx_ready.
- tx_valid  output  1  response byte available.
- tx_data  output  8  ASCII response byte.
- tx_ready  input  1  host consumes tx_data; a byte transfers when tx_valid && tx_ready.
- mux_out  output  WIDTH  combinational: sel ? b : a, computed from the registers.

Behaviour:
- Reset (rst=1 at a clock edge):
  - a=0, b=0, sel=0, tx_valid=0, tx_data=0, rx_ready=0.
  - State goes to CMD; the digit accumulator and error flag are cleared.
  - Reset mid-line or mid-response discards all partial input and output.
  - rx_ready rises the first cycle after rst deasserts.
- States: CMD, ARG, FLUSH, RESP.
- rx_ready:
  - rx_ready=1 in CMD, ARG and FLUSH; 0 in RESP.
  - No input is accepted while a response is pending.
- Whitespace: space (0x20) and CR (0x0D) are ignored in every RX state.
- CMD (waiting for the command letter):
  - '\n' (0x0A): empty line; no response; stay in CMD.
  - 'A', 'B', 'S': latch the letter, clear the accumulator, go to ARG.
  - 'R': go to ARG with no digits allowed.
  - Any other byte: set error, go to FLUSH.
  - Letters are uppercase only.
- ARG (collecting hex digits):
  - Digits accepted: '0'-'9', 'A'-'F', 'a'-'f'. Each one does acc = (acc<<4)|digit and increments a digit count.
  - A non-hex, non-whitespace byte sets error and goes to FLUSH.
  - A/B require 1..HEXD digits; 1 to HEXD digits are zero-extended.
  - S requires exactly 1 digit with value 0 or 1.
  - R requires 0 digits.
  - A violation (too many digits, or S value >1) sets error; the remaining bytes are consumed via FLUSH.
  - On '\n':
    - Empty argument for A/B/S: error.
    - Valid A/B/S: the register is written on the same edge that accepts the '\n'. mux_out reflects the new value the next cycle. Response is "K\n".
    - Valid R: the response is HEXD uppercase hex digits of mux_out, MSB first, then '\n'. mux_out is snapshotted on the '\n' edge.
  - Go to RESP.
- FLUSH: discard bytes until '\n'; then response is "?\n", go to RESP. Registers are unchanged on any error.
- RESP (transmitting the response):
  - tx_valid=1 from the cycle after the '\n' is accepted (latency 1).
  - tx_data is held stable until tx_ready.
  - Each handshake advances to the next byte. No bubbles: the next byte is presented in the cycle after the handshake.
  - After the '\n' byte handshakes: tx_valid=0, go to CMD, rx_ready=1 the same cycle.
  - tx_ready held low stalls indefinitely with no data change.
- rx_valid while rx_ready=0 has no effect; the host must hold its byte.
- rx_data values are don't-care when rx_valid=0.

Test Plan:
1. Reset, then send "A 3c\n", "B A5\n", "R\n" with tx_ready=1:
   - Responses are "K\n", "K\n", "3C\n".
   - mux_out=0x3C after the A write.
2. Send "S 1\n" then "R\n":
   - "K\n", then "A5\n".
   - mux_out=0xA5 one cycle after the S line's '\n' is accepted.
3. Error paths: "A 123\n", "S 2\n", "X\n", "A\n", "R 5\n":
   - Each returns "?\n".
   - a, b and sel are unchanged; a follow-up "R\n" returns the prior value.
4. Backpressure: send "R\n" with tx_ready=0 for 5 cycles, then toggle tx_ready 1/0:
   - tx_data holds '3' while stalled; bytes arrive in order "3","C","\n".
   - rx_ready=0 throughout; a byte offered then is not consumed.
5. Formatting: send "\n", "\r\n", then " A  0f \r\n":
   - No responses for the blank lines, then "K\n"; "R\n" then returns "0F\n" with sel=0.
6. Reset mid-operation:
   - Assert rst after "A 7"; after release, send "R\n" → "00\n".
   - Assert rst during the RESP of an "R" → tx_valid=0 the next cycle; a, b and sel clear.

Source files
------------

// File: rtl/cmd_line_responder.sv
// rtl/cmd_line_responder.sv - text command target: parses A/B/S/R lines, drives a 2:1 mux, answers over a byte stream
module cmd_line_responder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] mux_out
);
    localparam int HEXD = WIDTH / 4;
    localparam int CW   = $clog2(HEXD + 1);
    localparam int RW   = (HEXD + 1) * 8;
    localparam logic [CW-1:0] HEXD_C = CW'(HEXD);
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {S_CMD, S_ARG, S_FLUSH, S_RESP} state_t;
    typedef enum logic [1:0] {C_A, C_B, C_S, C_R} cmd_t;

    state_t            state_q;
    cmd_t              cmd_q;
    logic [WIDTH-1:0]  a_q, b_q, acc_q;
    logic              sel_q;
    logic [CW-1:0]     cnt_q;
    logic              rx_ready_q, tx_valid_q;
    logic [7:0]        tx_data_q;
    logic [RW-9:0]     buf_q;

    logic              rx_fire, is_ws, dig_ok, arg_ok, dig_bad;
    logic [3:0]        dig_val;
    logic [RW-1:0]     resp_d;

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign mux_out  = sel_q ? b_q : a_q;
    assign rx_ready = rx_ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign rx_fire  = rx_valid && rx_ready_q;
    assign is_ws    = (rx_data == 8'h20) || (rx_data == 8'h0D);

    always_comb begin
        dig_ok  = 1'b1;
        dig_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)
            dig_val = rx_data[3:0];
        else if ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66))
            dig_val = rx_data[3:0] + 4'd9;
        else
            dig_ok = 1'b0;
    end

    // A digit that would make the line invalid sends the rest of it to FLUSH.
    assign dig_bad = (cmd_q == C_R) || (cnt_q == HEXD_C) ||
                     ((cmd_q == C_S) && ((cnt_q != '0) || (dig_val > 4'd1)));
    assign arg_ok  = (state_q == S_ARG) && ((cmd_q == C_R) || (cnt_q != '0));

    // Full response string, first byte in the top slot; R snapshots mux_out.
    always_comb begin
        resp_d = '0;
        if (!arg_ok) begin
            resp_d[RW-1 -: 16] = {8'h3F, LF};
        end else if (cmd_q == C_R) begin
            for (int i = 0; i < HEXD; i++)
                resp_d[RW-1-8*i -: 8] = nib2asc(mux_out[WIDTH-1-4*i -: 4]);
            resp_d[7:0] = LF;
        end else begin
            resp_d[RW-1 -: 16] = {8'h4B, LF};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CMD;
            cmd_q      <= C_A;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            buf_q      <= '0;
        end else begin
            case (state_q)
                S_CMD: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire && !is_ws && rx_data != LF) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_ARG;
                        case (rx_data)
                            8'h41:   cmd_q <= C_A;
                            8'h42:   cmd_q <= C_B;
                            8'h53:   cmd_q <= C_S;
                            8'h52:   cmd_q <= C_R;
                            default: state_q <= S_FLUSH;
                        endcase
                    end
                end
                S_ARG, S_FLUSH: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire && rx_data == LF) begin
                        if (arg_ok) begin
                            case (cmd_q)
                                C_A:     a_q   <= acc_q;
                                C_B:     b_q   <= acc_q;
                                C_S:     sel_q <= acc_q[0];
                                default: ;
                            endcase
                        end
                        state_q    <= S_RESP;
                        rx_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= resp_d[RW-1 -: 8];
                        buf_q      <= resp_d[RW-9:0];
                    end else if (rx_fire && !is_ws && state_q == S_ARG) begin
                        if (!dig_ok || dig_bad) begin
                            state_q <= S_FLUSH;
                        end else begin
                            acc_q <= (acc_q << 4) | WIDTH'(dig_val);
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    rx_ready_q <= 1'b0;
                    if (tx_valid_q && tx_ready) begin
                        if (tx_data_q == LF) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_CMD;
                        end else begin
                            tx_data_q <= buf_q[RW-9 -: 8];
                            buf_q     <= buf_q << 8;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_line_responder.sv
// tb/tb_cmd_line_responder.sv - scoreboard bench for cmd_line_responder
module tb_cmd_line_responder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready = 1'b1;
    logic [WIDTH-1:0] mux_out;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    always #5 clk = ~clk;

    cmd_line_responder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mux_out(mux_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transmitted byte is compared with the head of the queue.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_byte: got %02h expected none", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_data !== mon_e) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h expected %02h", tx_data, mon_e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (n >= 300) check("rx_accept_timeout", 32'(n), 0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic line(input string cmd, input string resp);
        expect_str(resp);
        send_str(cmd);
        drain({"drain ", cmd.substr(0, 0)});
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_mux_out", 32'(mux_out), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rx_ready_after_rst", 32'(rx_ready), 1);

        // Basic writes and readback
        line("A 3c\n", "K\n");
        check("mux_after_a", 32'(mux_out), 32'h3C);
        line("B A5\n", "K\n");
        line("R\n", "3C\n");

        // sel switches mux the edge after the line ends
        expect_str("K\n");
        send_str("S 1");
        check("mux_before_s", 32'(mux_out), 32'h3C);
        send_str("\n");
        check("mux_after_s", 32'(mux_out), 32'hA5);
        drain("drain_s1");
        line("R\n", "A5\n");

        // Error paths leave registers unchanged
        line("A 123\n", "?\n");
        line("S 2\n", "?\n");
        line("X\n", "?\n");
        line("A\n", "?\n");
        line("R 5\n", "?\n");
        line("R\n", "A5\n");
        check("mux_after_errors", 32'(mux_out), 32'hA5);

        // Backpressure
        line("S 0\n", "K\n");
        tx_ready = 1'b0;
        expect_str("3C\n");
        send_str("R\n");
        check("tx_latency", 32'(tx_valid), 1);
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_tx_data", 32'(tx_data), 32'h33);
            check("stall_tx_valid", 32'(tx_valid), 1);
            check("stall_rx_ready", 32'(rx_ready), 0);
        end
        rx_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            tx_ready = ~tx_ready;
            n++;
        end
        tx_ready = 1'b1;
        check("toggle_drain", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        check("rx_ready_after_resp", 32'(rx_ready), 1);
        check("tx_valid_after_resp", 32'(tx_valid), 0);

        // Formatting
        send_str("\n");
        send_str("\015\n");
        repeat (3) @(posedge clk);
        #1;
        check("blank_no_resp", 32'(tx_valid), 0);
        line(" A  0f \015\n", "K\n");
        line("R\n", "0F\n");

        // Reset mid-line
        send_str("A 7");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midline_rst_rx_ready", 32'(rx_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midline_rx_ready_rise", 32'(rx_ready), 1);
        line("R\n", "00\n");

        // Reset during a response
        line("A 12\n", "K\n");
        line("B 34\n", "K\n");
        line("S 1\n", "K\n");
        tx_ready = 1'b0;
        send_str("R\n");
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("resp_pending_data", 32'(tx_data), 32'h33);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("resp_rst_tx_valid", 32'(tx_valid), 0);
        check("resp_rst_mux_out", 32'(mux_out), 0);
        check("resp_rst_rx_ready", 32'(rx_ready), 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        line("R\n", "00\n");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
